// File: rtl/kse_jtag_tdr_req_ctrl.sv
// TDR request gate for the KSE JTAG FSM: legality check, 1-cycle update->valid, valid held until ready.
// Updates while busy are dropped (overrun); sticky TAP status. Optional timeout flag: KSE_JTAG_TDR_TIMEOUT_EN.
package kse3_jtag_pkg;
  typedef struct packed {
    logic        ahb_valid;
    logic        ahb_hwrite;
    logic [2:0]  ahb_hsize;
    logic [31:0] ahb_haddr;
    logic [31:0] ahb_hwdata;
    logic        enter_jtag_access_mode;
    logic        init_kse3_adac_itf;
  } kse3_jtag_req_t;

  typedef struct packed {
    logic        cmd_ignored;
    logic        ahb_hresp;
    logic [31:0] ahb_hrdata;
  } kse3_jtag_resp_t;
endpackage

module kse_jtag_tdr_req_ctrl
  import kse3_jtag_pkg::*;
#(
  parameter int TimeoutCycles = 1024,
  parameter int TimeoutW      = $clog2(TimeoutCycles + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_tap_update,
  input  kse3_jtag_req_t  i_tap_req,
  input  logic            i_tap_capture,
  output logic [5:0]      o_tap_status,
  output kse3_jtag_resp_t o_tap_resp,
  output kse3_jtag_req_t  o_kse3_jtag_req,
  output logic            o_tdr_valid,
  input  logic            i_tdr_ready,
  input  kse3_jtag_resp_t i_kse3_jtag_resp
);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  state_t state;
  logic   done, ignored, reject, overrun, timeout;
  logic   legal, accept, handshake, set_reject, set_overrun;

  // Exactly one command kind, and AHB accesses must be word aligned.
  always_comb begin
    legal = 1'b0;
    case ({i_tap_req.ahb_valid, i_tap_req.enter_jtag_access_mode, i_tap_req.init_kse3_adac_itf})
      3'b100:         legal = (i_tap_req.ahb_haddr[1:0] == 2'b00);
      3'b010, 3'b001: legal = 1'b1;
      default:        legal = 1'b0;
    endcase
  end

  assign accept      = i_tap_update && (state == IDLE) && legal;
  assign set_reject  = i_tap_update && (state == IDLE) && !legal;
  assign set_overrun = i_tap_update && (state != IDLE);
  assign handshake   = (state == REQ) && i_tdr_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state           <= IDLE;
      o_tdr_valid     <= 1'b0;
      o_kse3_jtag_req <= '0;
      o_tap_resp      <= '0;
      done            <= 1'b0;
      ignored         <= 1'b0;
      reject          <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            o_kse3_jtag_req <= i_tap_req;
            o_tdr_valid     <= 1'b1;
            state           <= REQ;
          end
        end
        REQ: begin
          if (i_tdr_ready) begin
            o_tdr_valid <= 1'b0;
            o_tap_resp  <= i_kse3_jtag_resp;
            ignored     <= i_kse3_jtag_resp.cmd_ignored;
            state       <= GAP;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          o_tdr_valid <= 1'b0;
          state       <= IDLE;
        end
      endcase
      // Sticky flags: a set in the capture cycle wins over the clear.
      done    <= handshake   | (done    & ~i_tap_capture);
      reject  <= set_reject  | (reject  & ~i_tap_capture);
      overrun <= set_overrun | (overrun & ~i_tap_capture);
    end
  end

`ifdef KSE_JTAG_TDR_TIMEOUT_EN
  logic [TimeoutW-1:0] to_cnt;
  logic                set_timeout;

  assign set_timeout = (state == REQ) && !i_tdr_ready &&
                       (to_cnt == TimeoutW'(TimeoutCycles - 1));

  // Report-only: the handshake is never abandoned on timeout.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      if (accept) begin
        to_cnt <= '0;
      end else if ((state == REQ) && !i_tdr_ready && (to_cnt != TimeoutW'(TimeoutCycles))) begin
        to_cnt <= to_cnt + 1'b1;
      end
      timeout <= set_timeout | (timeout & ~i_tap_capture);
    end
  end
`else
  logic [TimeoutW-1:0] unused_timeout_cfg;
  assign unused_timeout_cfg = TimeoutW'(TimeoutCycles);
  assign timeout            = 1'b0;
`endif

  assign o_tap_status = {timeout, overrun, reject, ignored, done, (state != IDLE)};

endmodule
